// File: rtl/struct_example.sv
// Packed-record smoke pipeline: a counter-driven generator feeds two register stages,
// and an independent counter model checks every output after priming.
module struct_example #(
    parameter int                DATA_W    = 8,
    parameter int                MODE_W    = 2,
    parameter logic [DATA_W-1:0] XOR_KEY   = 8'hA5,
    parameter int                INJECT_AT = 0
) (
    input  logic clock,
    input  logic clear_n,
    output logic success
);

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] data;
    } rec_t;

    localparam logic [DATA_W-1:0] INJ_VAL = DATA_W'(INJECT_AT);

    logic [DATA_W-1:0] gen_cnt;
    logic [DATA_W-1:0] ref_cnt;
    logic [1:0]        prime_cnt;
    logic              err;
    rec_t              rec_in;
    rec_t              rec_q;
    logic [DATA_W-1:0] data_out;
    logic [MODE_W-1:0] mode_out;
    logic [DATA_W-1:0] exp_data;
    logic [MODE_W-1:0] exp_mode;
    logic              primed;
    logic              inject;
    logic              mismatch_now;

    // Fault hook: flip data bit0 of one generated record to prove the checker bites.
    assign inject = (INJECT_AT != 0) && (gen_cnt == INJ_VAL);

    always_comb begin
        rec_in      = '0;
        rec_in.mode = gen_cnt[MODE_W-1:0] ^ gen_cnt[2*MODE_W-1:MODE_W];
        rec_in.data = gen_cnt ^ {{(DATA_W-1){1'b0}}, inject};
    end

    assign primed       = (prime_cnt == 2'd2);
    assign exp_data     = ref_cnt ^ XOR_KEY;
    assign exp_mode     = (ref_cnt[MODE_W-1:0] ^ ref_cnt[2*MODE_W-1:MODE_W]) + MODE_W'(1);
    assign mismatch_now = primed && ((data_out != exp_data) || (mode_out != exp_mode));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            gen_cnt  <= '0;
            rec_q    <= '0;
            data_out <= '0;
            mode_out <= '0;
        end else begin
            gen_cnt  <= gen_cnt + DATA_W'(1);
            rec_q    <= rec_in;
            data_out <= rec_q.data ^ XOR_KEY;
            mode_out <= rec_q.mode + MODE_W'(1);
        end
    end

    // Reference side: waits two edges for the pipeline to fill, then counts in lockstep.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            prime_cnt <= '0;
            ref_cnt   <= '0;
            err       <= 1'b0;
            success   <= 1'b0;
        end else begin
            if (!primed)
                prime_cnt <= prime_cnt + 2'd1;
            if (primed)
                ref_cnt <= ref_cnt + DATA_W'(1);
            err     <= err | mismatch_now;
            success <= primed && !err && !mismatch_now;
        end
    end

endmodule

// File: tb/tb_struct_example.sv
// Bench for struct_example: a clean instance and a fault-injected instance share one reset;
// outputs are compared against a counter-index model of what each edge should show.
module tb_struct_example;

    logic clock = 1'b0;
    logic clear_n;
    logic success_a, success_b;

    int k;        // rising edges since last reset release
    int passed;
    int total;

    always #5 clock = ~clock;

    struct_example dut (
        .clock   (clock),
        .clear_n (clear_n),
        .success (success_a)
    );

    struct_example #(.INJECT_AT(5)) dut_inj (
        .clock   (clock),
        .clear_n (clear_n),
        .success (success_b)
    );

    typedef struct {
        int         en;
        logic [7:0] d;
        logic [1:0] m;
        logic       s;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, k);
    endtask

    // Record index n is the generator count that reaches the outputs at edge kk.
    function automatic int exp_d(input int kk, input bit inj);
        int n = (kk - 2) & 255;
        int d = n ^ 'hA5;
        if (inj && n == 5) d = d ^ 1;
        return d;
    endfunction

    function automatic int exp_m(input int kk);
        int n = (kk - 2) & 255;
        return (((n & 3) ^ ((n >> 2) & 3)) + 1) & 3;
    endfunction

    task automatic tick();
        @(posedge clock);
        k++;
        @(negedge clock);
    endtask

    task automatic check_edge();
        if (k >= 2) begin
            chk("data_a", int'(dut.data_out), exp_d(k, 1'b0));
            chk("mode_a", int'(dut.mode_out), exp_m(k));
            chk("data_b", int'(dut_inj.data_out), exp_d(k, 1'b1));
            chk("mode_b", int'(dut_inj.mode_out), exp_m(k));
        end
        chk("success_a", int'(success_a), (k >= 3) ? 1 : 0);
        chk("success_b", int'(success_b), (k >= 3 && k <= 7) ? 1 : 0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        k      = 0;
        tbl[0] = '{2, 8'hA5, 2'd1, 1'b0};
        tbl[1] = '{3, 8'hA4, 2'd2, 1'b1};
        tbl[2] = '{4, 8'hA7, 2'd3, 1'b1};
        tbl[3] = '{5, 8'hA6, 2'd0, 1'b1};
        tbl[4] = '{6, 8'hA1, 2'd2, 1'b1};

        // Held in reset across three edges
        clear_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_success_a", int'(success_a), 0);
        chk("rst_success_b", int'(success_b), 0);
        chk("rst_data", int'(dut.data_out), 0);
        chk("rst_mode", int'(dut.mode_out), 0);

        clear_n = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            while (k < tbl[i].en) tick();
            chk("tbl_data", int'(dut.data_out), int'(tbl[i].d));
            chk("tbl_mode", int'(dut.mode_out), int'(tbl[i].m));
            chk("tbl_success", int'(success_a), int'(tbl[i].s));
        end

        // Long run through the generator wrap; the injected copy must fail at record 5 and stay down
        while (k < 300) begin
            tick();
            check_edge();
            if (k == 7) chk("inj_data", int'(dut_inj.data_out), 'hA1);
            if (k == 258) chk("wrap_data", int'(dut.data_out), 'hA5);
        end

        // Randomized mid-run reset pulses, re-priming checked by the model
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 30);
            repeat (n) begin
                tick();
                check_edge();
            end
            #2 clear_n = 1'b0;
            #1;
            chk("async_data", int'(dut.data_out), 0);
            chk("async_mode", int'(dut.mode_out), 0);
            chk("async_success_a", int'(success_a), 0);
            chk("async_success_b", int'(success_b), 0);
            repeat ($urandom_range(1, 3)) @(negedge clock);
            clear_n = 1'b1;
            k = 0;
        end
        repeat (12) begin
            tick();
            check_edge();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
